adc_capture_hls_deadlock_axis_monitor: RTL
==========================================

// Module: adc_capture_hls_deadlock_axis_monitor
// PURPOSE
//  Parametrised successor of the per-loop AXIS deadlock monitor.
//  Watches NUM_AXIS AXIS stall flags from one HLS pipeline (e.g. the pair_iq_df_flat read loop).
//  Flags a deadlock only after a stall has persisted THRESHOLD consecutive cycles.
//  Adds per-channel masking, a sticky latch with the ID of the first offending channel, and a stall-duration counter.
//  Feeds the top-level deadlock aggregator and debug registers.
// PARAMETERS
//  NUM_AXIS   2   number of monitored AXIS stall flags (>=1)
//  THRESHOLD  1   consecutive stalled cycles before a channel qualifies (>=1); 1 reproduces legacy timing
//  CNT_WIDTH  16  width of per-channel persistence counters and of block_duration; counters saturate
//  ID_WIDTH   1   width of block_chan_id, = max(1,$clog2(NUM_AXIS))
// PORTS
//  clock            in   1          sole clock, rising edge
//  reset_n          in   1          asynchronous active-low reset
//  axis_block_sigs  in   NUM_AXIS   per-channel stall flag, 1 = stalled this cycle
//  axis_enable      in   NUM_AXIS   per-channel monitor enable, 0 = channel ignored
//  clear            in   1          synchronous clear of sticky/capture state
//  block            out  1          live deadlock indication (registered)
//  block_sticky     out  1          latched deadlock flag, held until clear
//  block_chan_id    out  ID_WIDTH   index of the first channel that qualified
//  block_duration   out  CNT_WIDTH  cycles block has been high in the current episode, saturating
//  state            out  2          FSM state, for debug: 0 IDLE, 1 PENDING, 2 BLOCKED
// BEHAVIOUR
//  Reset (reset_n=0, async): all counters 0, block=0, block_sticky=0, block_chan_id=0, block_duration=0, state=IDLE.
//  Effective stall: stall_i = axis_block_sigs[i] & axis_enable[i].
//  Per-channel counter cnt_i, each edge:
//   - stall_i: cnt_i <= sat(cnt_i+1)
//   - else:    cnt_i <= 0
//  Qualified (combinational): qual_i = stall_i & (cnt_i+1 >= THRESHOLD); compare at CNT_WIDTH+1 bits, no wrap.
//  Latency: block rises at the edge ending the THRESHOLD-th consecutive stalled cycle.
//   - THRESHOLD=1: one edge after the stall is first seen (legacy behaviour).
//  block <= |qual; block falls one edge after all qual_i are 0.
//  A single non-stalled cycle restarts that channel's count.
//  FSM:
//   - IDLE -> PENDING when any stall_i and no qual_i.
//   - IDLE or PENDING -> BLOCKED when any qual_i.
//   - PENDING -> IDLE when no stall_i.
//   - BLOCKED -> PENDING when no qual_i but some stall_i.
//   - BLOCKED -> IDLE when no stall_i.
//  block_duration:
//   - Loads 1 on IDLE/PENDING->BLOCKED.
//   - Increments (saturating at all-ones) while in BLOCKED.
//   - Holds its last value after leaving BLOCKED.
//   - Zeroed by clear only.
//  block_sticky / block_chan_id:
//   - Set on the first qual while block_sticky=0.
//   - ID = lowest qualifying index when several qualify in the same cycle.
//   - Later qualifications do not overwrite.
//  clear:
//   - Zeroes block_sticky, block_chan_id and block_duration; counters and FSM unaffected.
//   - clear with a qualifying channel in the same cycle: the set wins (sticky=1, new ID captured).
//   - Duration reload: if the FSM is in or enters BLOCKED on that edge, duration loads 1.
//  Deasserting axis_enable[i] mid-stall zeroes cnt_i next edge; block drops if no other channel qualifies.
//  Reset mid-episode: immediate return to reset values; no partial state is retained.
// STRUCTURE
//  Shared package adc_capture_dbg_pkg:
//   - state encoding localparams MON_IDLE/MON_PENDING/MON_BLOCKED.
//   - function sat_inc(value, width).
//   - function clog2_min1.
//  One sub-module, deadlock_persist_cnt: one channel's counter and qual output; generate NUM_AXIS instances.
//  Priority encoder, FSM, sticky capture and duration counter live in the top.
// TESTING
//  1. NUM_AXIS=2, THRESHOLD=1: pulse sig[1] for 1 cycle -> block high exactly 1 cycle, 1 edge later; sticky=1, chan_id=1, duration=1.
//  2. THRESHOLD=4: stall ch0 3 cycles, gap 1, then 4 cycles -> no block on the first burst.
//     block rises at the edge ending the 4th cycle of the second burst; state PENDING->BLOCKED.
//  3. Both channels qualify on the same cycle -> chan_id=0.
//     Then ch0 drops with ch1 still stalled -> block stays 1, state stays BLOCKED.
//  4. axis_enable=2'b01 with sig[1] held high 20 cycles -> block and sticky stay 0, state IDLE.
//  5. CNT_WIDTH=4: stall held 40 cycles -> block_duration saturates at 15 without wrapping.
//     clear pulsed while still stalled -> sticky re-set, duration reloaded to 1.
//  6. Assert reset_n=0 asynchronously mid-BLOCKED -> all outputs 0 before the next clock edge.
//     After release with the stall still present, block returns after THRESHOLD cycles.

Source files
------------

// File: rtl/adc_capture_dbg_pkg.sv
// Shared debug-monitor definitions: FSM state encoding and small
// arithmetic helpers used by the deadlock monitor and its channel counters.
package adc_capture_dbg_pkg;

  localparam int MON_STATE_W = 2;

  // Debug-visible FSM encoding; the numeric values are read by software.
  typedef enum logic [MON_STATE_W-1:0] {
    MON_IDLE    = 2'd0,
    MON_PENDING = 2'd1,
    MON_BLOCKED = 2'd2
  } mon_state_e;

  // Saturating increment of a value that is 'width' bits wide (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    if (width >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (value >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

  // Ceiling log2 that never returns less than 1, so a single-channel
  // build still has a 1-bit channel ID.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((32'sd1 <<< k) < n) begin
        r = k + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/deadlock_persist_cnt.sv
// One channel's stall-persistence counter. qual goes high during the cycle
// in which the channel completes THRESHOLD consecutive stalled cycles and
// stays high for as long as the stall persists.
module deadlock_persist_cnt
  import adc_capture_dbg_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int THRESHOLD = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall,
  output logic qual
);

  // Threshold at one bit wider than the counter so cnt+1 can never wrap.
  localparam logic [CNT_WIDTH:0] THR_C = (CNT_WIDTH + 1)'(THRESHOLD);

  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH:0]   cnt_plus1_s;

  // Count consecutive stalled cycles, saturating; any gap restarts from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (stall) begin
      cnt_r <= CNT_WIDTH'(sat_inc(32'(cnt_r), CNT_WIDTH));
    end else begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end
  end

  // Qualify when this cycle's stall would bring the run up to the threshold.
  always_comb begin
    cnt_plus1_s = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
    qual        = stall & (cnt_plus1_s >= THR_C);
  end

endmodule

// File: rtl/adc_capture_hls_deadlock_axis_monitor.sv
// AXIS deadlock monitor for one HLS pipeline: per-channel persistence
// filtering, live/sticky deadlock flags, first-offender ID capture and a
// saturating duration counter for the current blocked episode.
module adc_capture_hls_deadlock_axis_monitor
  import adc_capture_dbg_pkg::*;
#(
  parameter int NUM_AXIS  = 2,
  parameter int THRESHOLD = 1,
  parameter int CNT_WIDTH = 16,
  parameter int ID_WIDTH  = clog2_min1(NUM_AXIS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_AXIS-1:0]  axis_block_sigs,
  input  logic [NUM_AXIS-1:0]  axis_enable,
  input  logic                 clear,
  output logic                 block,
  output logic                 block_sticky,
  output logic [ID_WIDTH-1:0]  block_chan_id,
  output logic [CNT_WIDTH-1:0] block_duration,
  output logic [1:0]           state
);

  logic [NUM_AXIS-1:0]  stall_s;
  logic [NUM_AXIS-1:0]  qual_s;
  logic                 any_stall_s;
  logic                 any_qual_s;
  logic [ID_WIDTH-1:0]  first_id_s;
  logic [CNT_WIDTH-1:0] dur_idle_s;
  logic [CNT_WIDTH-1:0] dur_inc_s;

  mon_state_e           state_r;
  logic                 block_r;
  logic                 sticky_r;
  logic [ID_WIDTH-1:0]  chan_id_r;
  logic [CNT_WIDTH-1:0] duration_r;

  assign stall_s = axis_block_sigs & axis_enable;

  for (genvar g = 0; g < NUM_AXIS; g++) begin : g_chan
    deadlock_persist_cnt #(
      .CNT_WIDTH (CNT_WIDTH),
      .THRESHOLD (THRESHOLD)
    ) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .stall   (stall_s[g]),
      .qual    (qual_s[g])
    );
  end

  // Reduce channel status and pick the lowest qualifying channel index.
  always_comb begin
    any_stall_s = |stall_s;
    any_qual_s  = |qual_s;
    first_id_s  = {ID_WIDTH{1'b0}};
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      first_id_s = qual_s[i] ? ID_WIDTH'(i) : first_id_s;
    end
  end

  // Duration candidates: value kept outside BLOCKED (clear zeroes it) and
  // the saturating step taken while BLOCKED persists.
  always_comb begin
    dur_idle_s = clear ? {CNT_WIDTH{1'b0}} : duration_r;
    dur_inc_s  = CNT_WIDTH'(sat_inc(32'(duration_r), CNT_WIDTH));
  end

  // Monitor FSM with the live block flag and episode duration registered alongside.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= MON_IDLE;
      block_r    <= 1'b0;
      duration_r <= {CNT_WIDTH{1'b0}};
    end else begin
      block_r <= any_qual_s;
      case (state_r)
        MON_IDLE, MON_PENDING: begin
          if (any_qual_s) begin
            state_r    <= MON_BLOCKED;
            duration_r <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end else if (any_stall_s) begin
            state_r    <= MON_PENDING;
            duration_r <= dur_idle_s;
          end else begin
            state_r    <= MON_IDLE;
            duration_r <= dur_idle_s;
          end
        end
        MON_BLOCKED: begin
          if (any_qual_s) begin
            state_r    <= MON_BLOCKED;
            // A clear during a continuing episode restarts the count at 1.
            duration_r <= clear ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : dur_inc_s;
          end else if (any_stall_s) begin
            state_r    <= MON_PENDING;
            duration_r <= dur_idle_s;
          end else begin
            state_r    <= MON_IDLE;
            duration_r <= dur_idle_s;
          end
        end
        default: begin
          state_r    <= MON_IDLE;
          duration_r <= dur_idle_s;
        end
      endcase
    end
  end

  // Sticky flag and first-offender ID; a new qualification beats a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_r  <= 1'b0;
      chan_id_r <= {ID_WIDTH{1'b0}};
    end else if (any_qual_s && (!sticky_r || clear)) begin
      sticky_r  <= 1'b1;
      chan_id_r <= first_id_s;
    end else if (clear) begin
      sticky_r  <= 1'b0;
      chan_id_r <= {ID_WIDTH{1'b0}};
    end else begin
      sticky_r  <= sticky_r;
      chan_id_r <= chan_id_r;
    end
  end

  assign block          = block_r;
  assign block_sticky   = sticky_r;
  assign block_chan_id  = chan_id_r;
  assign block_duration = duration_r;
  assign state          = state_r;

endmodule
